tick_rate_gen: RTL and testbench

Programmable rate divider and pause controller that sits directly upstream of the single-digit BCD counter/HEX0 stage. It divides CLOCK_50 into a one-cycle `tick` enable at a switch-selected rate. A pushbutton toggles between running and paused. The digit counter advances only on `tick`, so its own 50 M comparison is removed.

---
 rtl/tick_rate_pkg.sv | 27 ++
 rtl/key_conditioner.sv | 75 +++++++
 rtl/tick_rate_gen.sv | 94 +++++++++
 tb/tb_tick_rate_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tick_rate_pkg.sv
// Shared constants for the tick rate divider: speed codes, run/pause state
// encoding and the speed-code to terminal-count mapping.
package tick_rate_pkg;

  localparam logic [1:0] SPD_1HZ  = 2'b00;
  localparam logic [1:0] SPD_2HZ  = 2'b01;
  localparam logic [1:0] SPD_4HZ  = 2'b10;
  localparam logic [1:0] SPD_HALF = 2'b11;

  localparam logic ST_RUN    = 1'b1;
  localparam logic ST_PAUSED = 1'b0;

  // Terminal count for a speed code; the tick period is this value plus one.
  function automatic logic [31:0] speed_terminal(input logic [1:0] spd,
                                                 input int unsigned clk_hz);
    logic [31:0] t;
    case (spd)
      SPD_1HZ:  t = clk_hz - 32'd1;
      SPD_2HZ:  t = (clk_hz / 32'd2) - 32'd1;
      SPD_4HZ:  t = (clk_hz / 32'd4) - 32'd1;
      SPD_HALF: t = (32'd2 * clk_hz) - 32'd1;
      default:  t = clk_hz - 32'd1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/key_conditioner.sv
// Pause key conditioning: 2-flop synchronizer, optional debounce (enabled by
// defining TICK_DEBOUNCE_EN) and a falling-edge detector giving a press pulse.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic press_o
);

  logic key_meta_q;
  logic key_sync_q;
  logic key_cond_s;
  logic key_prev_q;

  // Synchronizer resets to the released (high) level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
    end else begin
      key_meta_q <= key_i;
      key_sync_q <= key_meta_q;
    end
  end

`ifdef TICK_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            key_db_q, key_db_d;

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples.
  always_comb begin
    db_cnt_d = db_cnt_q;
    key_db_d = key_db_q;
    if (key_sync_q == key_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      key_db_d = key_sync_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_cnt_q <= '0;
      key_db_q <= 1'b1;
    end else begin
      db_cnt_q <= db_cnt_d;
      key_db_q <= key_db_d;
    end
  end

  assign key_cond_s = key_db_q;
`else
  assign key_cond_s = key_sync_q;
`endif

  // Previous conditioned level for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_prev_q <= 1'b1;
    end else begin
      key_prev_q <= key_cond_s;
    end
  end

  assign press_o = key_prev_q & ~key_cond_s;

endmodule

// File: rtl/tick_rate_gen.sv
// Programmable tick divider with run/pause toggle for the BCD digit stage.
// Optional key debounce is enabled by defining TICK_DEBOUNCE_EN.
module tick_rate_gen
  import tick_rate_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int          CNT_W           = 27,
  parameter int          DEBOUNCE_CYCLES = 500_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [1:0] speed_sel,
  input  logic       pause_key,
  output logic       tick,
  output logic       running
);

  logic [1:0]       spd_meta_q, spd_sync_q, spd_prev_q;
  logic             spd_chg_s;
  logic [CNT_W-1:0] term_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             state_q, state_d;
  logic             press_s;

  key_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk_i  (CLOCK_50),
    .rst_ni (reset),
    .key_i  (pause_key),
    .press_o(press_s)
  );

  // Speed switch synchronizer plus a copy of the last seen value.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      spd_meta_q <= SPD_1HZ;
      spd_sync_q <= SPD_1HZ;
      spd_prev_q <= SPD_1HZ;
    end else begin
      spd_meta_q <= speed_sel;
      spd_sync_q <= spd_meta_q;
      spd_prev_q <= spd_sync_q;
    end
  end

  assign spd_chg_s = (spd_sync_q != spd_prev_q);
  assign term_s    = CNT_W'(speed_terminal(spd_sync_q, CLK_HZ));

  // Divider: a speed change overrides everything so the count never exceeds T.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (spd_chg_s) begin
      cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      if (cnt_q == term_s) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Each press flips between RUN and PAUSED.
  always_comb begin
    if (press_s) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
    end else begin
      state_d = state_q;
    end
  end

  // Divider, tick and state registers.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      state_q <= state_d;
    end
  end

  assign tick    = tick_q;
  assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_tick_rate_gen.sv
// Directed bench for tick_rate_gen at CLK_HZ=8, DEBOUNCE_CYCLES=4.
module tb_tick_rate_gen;

`ifdef TICK_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif
  localparam int P = LAT + 1;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [1:0] speed_sel;
  logic       pause_key;
  logic       tick;
  logic       running;

  int n_checks = 0;
  int n_pass   = 0;
  int n;

  tick_rate_gen #(
    .CLK_HZ(8),
    .CNT_W(5),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .speed_sel(speed_sel),
    .pause_key(pause_key),
    .tick     (tick),
    .running  (running)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int cyc);
    for (int i = 0; i < cyc; i++) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  // Edges until tick is seen high, capped at budget.
  task automatic wait_tick(input int budget, output int cnt);
    cnt = 0;
    do begin
      @(posedge CLOCK_50);
      #1;
      cnt++;
    end while (!tick && cnt < budget);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    speed_sel = 2'b00;
    pause_key = 1'b1;
    step(3);
    check_eq("rst_tick", int'(tick), 0);
    check_eq("rst_running", int'(running), 1);
    reset = 1'b1;

    wait_tick(40, n);
    check_eq("first_tick", n, 8);
    check_eq("run_after_rst", int'(running), 1);
    step(1);
    check_eq("tick_width", int'(tick), 0);
    wait_tick(40, n);
    check_eq("period_00_rest", n, 7);
    wait_tick(40, n);
    check_eq("period_00", n, 8);

    // Count reaches new T exactly when the change lands: change wins.
    step(1);
    speed_sel = 2'b01;
    wait_tick(40, n);
    check_eq("term_vs_spdchg", n, 7);
    wait_tick(40, n);
    check_eq("period_01", n, 4);

    speed_sel = 2'b11;
    wait_tick(40, n);
    check_eq("first_11", n, 19);
    wait_tick(40, n);
    check_eq("period_11", n, 16);

    speed_sel = 2'b10;
    wait_tick(40, n);
    check_eq("first_10", n, 5);
    wait_tick(40, n);
    check_eq("period_10", n, 2);

    speed_sel = 2'b00;
    wait_tick(40, n);
    check_eq("old_rate_tick", n, 2);
    wait_tick(40, n);
    check_eq("first_00", n, 9);
    wait_tick(40, n);
    check_eq("period_00_again", n, 8);

    // Pause mid-period, count held at P.
    pause_key = 1'b0;
    step(LAT);
    check_eq("pause_latency", int'(running), 1);
    step(1);
    check_eq("paused", int'(running), 0);
    step(6);
    pause_key = 1'b1;
    wait_tick(20, n);
    check_eq("no_tick_paused", n, 20);
    check_eq("no_tick_paused_lvl", int'(tick), 0);
    pause_key = 1'b0;
    step(LAT);
    check_eq("resume_latency", int'(running), 0);
    step(1);
    check_eq("resumed", int'(running), 1);
    wait_tick(40, n);
    check_eq("resume_partial", n, 8 - P);
    pause_key = 1'b1;
    step(12);

    // Press landing on the terminal-count cycle.
    wait_tick(40, n);
    step(7 - LAT);
    pause_key = 1'b0;
    step(LAT);
    check_eq("pre_term_run", int'(running), 1);
    step(1);
    check_eq("term_press_tick", int'(tick), 1);
    check_eq("term_press_paused", int'(running), 0);
    step(6);
    pause_key = 1'b1;
    wait_tick(20, n);
    check_eq("no_tick_paused2", n, 20);
    pause_key = 1'b0;
    step(LAT + 1);
    check_eq("resumed2", int'(running), 1);
    wait_tick(40, n);
    check_eq("count_was_cleared", n, 8);
    pause_key = 1'b1;
    step(12);

`ifdef TICK_DEBOUNCE_EN
    pause_key = 1'b0;
    step(2);
    pause_key = 1'b1;
    step(12);
    check_eq("glitch_ignored", int'(running), 1);
    pause_key = 1'b0;
    step(6);
    check_eq("db_before_toggle", int'(running), 1);
    pause_key = 1'b1;
    step(1);
    check_eq("db_toggle", int'(running), 0);
    step(12);
    check_eq("db_release_no_event", int'(running), 0);
    pause_key = 1'b0;
    step(6);
    pause_key = 1'b1;
    step(1);
    check_eq("db_toggle_back", int'(running), 1);
    step(12);
`endif

    // Held key gives exactly one event.
    pause_key = 1'b0;
    step(LAT + 1);
    check_eq("hold_toggle", int'(running), 0);
    step(40);
    check_eq("hold_once", int'(running), 0);
    pause_key = 1'b1;
    step(12);
    check_eq("hold_release", int'(running), 0);

    // Asynchronous reset while paused.
    check_eq("pre_rst_paused", int'(running), 0);
    reset = 1'b0;
    #1;
    check_eq("async_rst_tick", int'(tick), 0);
    check_eq("async_rst_running", int'(running), 1);
    step(2);
    reset = 1'b1;
    wait_tick(40, n);
    check_eq("post_rst_period", n, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
